// File: rtl/pkg_vid_axis.sv
// Shared constants and helpers for the video AXI4-Stream blocks.
// Modules derive their own widths from their parameters through these helpers.
package pkg_vid_axis;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int keep_width(input int pack, input int data_bits);
        return pack * data_bits / 8;
    endfunction

    // A single-lane counter still needs one bit.
    function automatic int lane_width(input int pack);
        return (pack > 1) ? clog2(pack) : 1;
    endfunction

    localparam int DATA_BITS_DEF = 8;
    localparam int PACK_DEF      = 4;
    localparam int KEEP_W        = keep_width(PACK_DEF, DATA_BITS_DEF);
    localparam int LANE_W        = lane_width(PACK_DEF);

endpackage

// File: rtl/axis_reg_slice.sv
// Output register for an AXI4-Stream master: holds the beat while stalled,
// drops tvalid on the handshake unless a new word is loaded on the same edge.
module axis_reg_slice #(
    parameter int DW = 32,
    parameter int KW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic [KW-1:0] keep_i,
    input  logic          last_i,
    input  logic          user_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [KW-1:0] keep_o,
    output logic          last_o,
    output logic          user_o,
    output logic          ready_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic [KW-1:0] keep_q;
    logic          last_q;
    logic          user_q;

    // Upstream may only load when this is high.
    assign ready_o = !valid_q || ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            keep_q  <= keep_i;
            last_q  <= last_i;
            user_q  <= user_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign last_o  = last_q;
    assign user_o  = user_q;

endmodule

// File: rtl/axis_pixel_packer.sv
// Packs PACK narrow pixels into one wide AXI4-Stream word, first pixel in the LSBs,
// keeping SOF/EOL markers, zero-padding short line ends and flagging misaligned SOF.
module axis_pixel_packer
    import pkg_vid_axis::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int PACK      = PACK_DEF
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [DATA_BITS-1:0]      s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tuser,
    output logic [PACK*DATA_BITS-1:0] m_axis_tdata,
    output logic [PACK*DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic                      sof_err
);

    localparam int WORD_W = PACK * DATA_BITS;
    localparam int KW     = keep_width(PACK, DATA_BITS);
    localparam int LW     = lane_width(PACK);
    localparam int BPL    = DATA_BITS / 8;

    logic [LW-1:0]     lane_q, lane_d, lane_eff;
    logic [WORD_W-1:0] acc_q, acc_d, acc_eff, merged;
    logic [KW-1:0]     word_keep;
    logic              sof_pend_q, sof_pend_d;
    logic              sof_err_q, sof_err_d;
    logic              slice_ready, accept, misalign, complete, word_user;

    assign s_axis_tready = slice_ready;
    assign accept        = s_axis_tvalid && slice_ready;

    // A misaligned SOF restarts the word: the pixel behaves as if it arrived at lane 0.
    assign misalign  = accept && s_axis_tuser && (lane_q != '0);
    assign lane_eff  = misalign ? '0 : lane_q;
    assign acc_eff   = misalign ? '0 : acc_q;
    assign complete  = accept && ((lane_eff == LW'(PACK - 1)) || s_axis_tlast);
    assign word_user = (lane_eff == '0) ? s_axis_tuser : sof_pend_q;

    always_comb begin
        merged    = acc_eff;
        word_keep = '0;
        for (int i = 0; i < PACK; i++) begin
            if (LW'(i) == lane_eff) begin
                merged[i*DATA_BITS +: DATA_BITS] = s_axis_tdata;
            end
            if (LW'(i) <= lane_eff) begin
                word_keep[i*BPL +: BPL] = {BPL{1'b1}};
            end
        end
    end

    always_comb begin
        lane_d     = lane_q;
        acc_d      = acc_q;
        sof_pend_d = sof_pend_q;
        sof_err_d  = misalign;
        if (complete) begin
            lane_d     = '0;
            acc_d      = '0;
            sof_pend_d = 1'b0;
        end else if (accept) begin
            lane_d     = lane_eff + 1'b1;
            acc_d      = merged;
            sof_pend_d = word_user;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lane_q     <= '0;
            acc_q      <= '0;
            sof_pend_q <= 1'b0;
            sof_err_q  <= 1'b0;
        end else begin
            lane_q     <= lane_d;
            acc_q      <= acc_d;
            sof_pend_q <= sof_pend_d;
            sof_err_q  <= sof_err_d;
        end
    end

    assign sof_err = sof_err_q;

    axis_reg_slice #(
        .DW(WORD_W),
        .KW(KW)
    ) u_out_slice (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .load_i  (complete),
        .data_i  (merged),
        .keep_i  (word_keep),
        .last_i  (s_axis_tlast),
        .user_i  (word_user),
        .ready_i (m_axis_tready),
        .valid_o (m_axis_tvalid),
        .data_o  (m_axis_tdata),
        .keep_o  (m_axis_tkeep),
        .last_o  (m_axis_tlast),
        .user_o  (m_axis_tuser),
        .ready_o (slice_ready)
    );

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Bench for axis_pixel_packer (8-bit pixels, 4 per word): directed line scenarios
// plus randomized lines, scored against a pixel-list model of the packer.
module tb_axis_pixel_packer;

    localparam int DB = 8;
    localparam int PK = 4;
    localparam int WW = DB * PK;
    localparam int KW = WW / 8;
    localparam int BW = WW + KW + 2;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DB-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic [WW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          sof_err;

    axis_pixel_packer #(
        .DATA_BITS(DB),
        .PACK(PK)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .sof_err       (sof_err)
    );

    // ---------------- clock ----------------
    always #5 aclk = ~aclk;

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [DB-1:0] pend_q[$];
    logic          pend_user = 1'b0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] rx_q[$];
    logic          exp_sof = 1'b0;
    int            beat_cnt = 0;
    int            sof_cnt = 0;

    function automatic void model_step(input logic [DB-1:0] d, input logic l, input logic u);
        logic [WW-1:0] w;
        logic [KW-1:0] k;
        if (u && pend_q.size() != 0) begin
            pend_q.delete();
            exp_sof = 1'b1;
        end
        if (pend_q.size() == 0) pend_user = u;
        pend_q.push_back(d);
        if (pend_q.size() == PK || l) begin
            w = '0;
            foreach (pend_q[i]) w[i*DB +: DB] = pend_q[i];
            k = KW'((1 << (pend_q.size() * DB / 8)) - 1);
            exp_q.push_back({pend_user, l, k, w});
            pend_q.delete();
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic          stall_active = 1'b0;
    logic [BW-1:0] stall_beat = '0;
    logic [BW-1:0] cur_beat;
    assign cur_beat = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};

    always @(negedge aclk) begin
        if (!aresetn) begin
            pend_q.delete();
            exp_q.delete();
            exp_sof      = 1'b0;
            stall_active = 1'b0;
        end else begin
            check("sof_err", sof_err, exp_sof);
            if (sof_err === 1'b1) sof_cnt++;
            exp_sof = 1'b0;
            check("s_tready", s_axis_tready, !(m_axis_tvalid && !m_axis_tready));
            if (stall_active) check("stall_hold", {m_axis_tvalid, cur_beat}, {1'b1, stall_beat});
            stall_active = m_axis_tvalid && !m_axis_tready;
            stall_beat   = cur_beat;
            if (m_axis_tvalid && m_axis_tready) begin
                beat_cnt++;
                rx_q.push_back(cur_beat);
                if (exp_q.size() == 0) check("beat_extra", 1, 0);
                else check("beat", cur_beat, exp_q.pop_front());
            end
            if (s_axis_tvalid && s_axis_tready) model_step(s_axis_tdata, s_axis_tlast, s_axis_tuser);
        end
    end

    // ---------------- downstream ready driver ----------------
    int rdy_mode = 0;
    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DB-1:0] d, input logic l, input logic u);
        bit ok;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge aclk);
            ok = s_axis_tready;
            @(posedge aclk);
            #1;
        end
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        bit done;
        s_axis_tvalid = 1'b0;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(posedge aclk);
            #2;
            done = (exp_q.size() == 0) && !m_axis_tvalid;
        end
        if (!done) check("drain_timeout", 0, 1);
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        s_axis_tvalid = 1'b0;
        aresetn = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    int b0, s0, len;

    initial begin
        // Reset held with input valid asserted.
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'h5A;
        repeat (5) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tkeep", m_axis_tkeep, 0);
        check("rst_tlast_tuser", {m_axis_tlast, m_axis_tuser}, 0);
        check("rst_sof_err", sof_err, 0);
        check("rst_s_tready", s_axis_tready, 1);
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        aresetn = 1'b1;
        idle(3);
        check("rst_no_beat", beat_cnt, 0);

        // Full line of two words.
        b0 = beat_cnt;
        for (int i = 1; i <= 8; i++) send(DB'(i), i == 8, i == 1);
        drain();
        check("full_count", beat_cnt - b0, 2);
        check("full_w0", rx_q[b0], {1'b1, 1'b0, 4'hF, 32'h04030201});
        check("full_w1", rx_q[b0+1], {1'b0, 1'b1, 4'hF, 32'h08070605});

        // Partial line end.
        b0 = beat_cnt;
        for (int i = 0; i < 6; i++) send(DB'(8'hA0 + i), i == 5, 1'b0);
        drain();
        check("part_count", beat_cnt - b0, 2);
        check("part_w0", rx_q[b0], {1'b0, 1'b0, 4'hF, 32'hA3A2A1A0});
        check("part_w1", rx_q[b0+1], {1'b0, 1'b1, 4'h3, 32'h0000A5A4});

        // Backpressure toggling every cycle over a 960-pixel line.
        b0 = beat_cnt;
        rdy_mode = 1;
        for (int i = 0; i < 960; i++) send(DB'($urandom), i == 959, i == 0);
        drain();
        rdy_mode = 0;
        idle(2);
        check("bp_count", beat_cnt - b0, 240);

        // SOF arriving mid-word.
        b0 = beat_cnt;
        s0 = sof_cnt;
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b0, 1'b1);
        send(8'h44, 1'b0, 1'b0);
        send(8'h55, 1'b0, 1'b0);
        send(8'h66, 1'b1, 1'b0);
        drain();
        check("sof_pulses", sof_cnt - s0, 1);
        check("sof_count", beat_cnt - b0, 1);
        check("sof_word", rx_q[b0], {1'b1, 1'b1, 4'hF, 32'h66554433});

        // Reset in the middle of a word.
        for (int i = 0; i < 3; i++) send(DB'($urandom), 1'b0, 1'b0);
        do_reset(1);
        b0 = beat_cnt;
        for (int i = 0; i < 4; i++) send(DB'(8'hB0 + i), 1'b0, 1'b0);
        drain();
        check("rstmid_count", beat_cnt - b0, 1);
        check("rstmid_word", rx_q[b0], {1'b0, 1'b0, 4'hF, 32'hB3B2B1B0});

        // Randomized lines with gaps, random backpressure and stray SOFs.
        rdy_mode = 2;
        for (int ln = 0; ln < 150; ln++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                send(DB'($urandom), i == len - 1,
                     (i == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0));
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            end
        end
        drain();
        rdy_mode = 0;
        idle(2);
        check("rand_leftover", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
